// File: rtl/ifu_prefetch_queue.sv
// Instruction-fetch front end: one fetch per cycle into a MEM_LAT-stage return line,
// a DEPTH-entry {pc,inst} FIFO toward decode, redirect flush, and terminal halt on ebreak.
// The fetch()/halt() calls are a port pair: fetch_inst_i answers fetch_pc_o in the same cycle.
module ifu_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MEM_LAT  = 1,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            halted,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  input  logic [31:0]     fetch_inst_i,
  output logic            halt_valid_o,
  output logic [31:0]     halt_inst_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

  logic [XLEN-1:0] q_pc_q   [DEPTH];
  logic [XLEN-1:0] q_pc_d   [DEPTH];
  logic [31:0]     q_inst_q [DEPTH];
  logic [31:0]     q_inst_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [MEM_LAT-1:0] dl_valid_q, dl_valid_d;
  logic [XLEN-1:0]    dl_pc_q   [MEM_LAT];
  logic [XLEN-1:0]    dl_pc_d   [MEM_LAT];
  logic [31:0]        dl_inst_q [MEM_LAT];
  logic [31:0]        dl_inst_d [MEM_LAT];

  int unsigned inflight;
  logic        run, pop, ebreak_hit, flush, issue, push;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + 32'(dl_valid_q[i]);
    end
  end

  always_comb begin
    run        = (state_q == S_RUN);
    out_valid  = run && (count_q != '0);
    out_pc     = out_valid ? q_pc_q[head_q]   : '0;
    out_inst   = out_valid ? q_inst_q[head_q] : '0;
    halted     = (state_q == S_HALT);

    pop        = out_valid && out_ready;
    ebreak_hit = pop && (q_inst_q[head_q] == EBREAK);
    flush      = run && (redirect_valid || ebreak_hit);
    // Credit counts in-flight slots so a returning slot always finds a free entry.
    issue      = run && reset && !flush && ((32'(count_q) + inflight) < DEPTH);
    push       = dl_valid_q[MEM_LAT-1] && !flush;

    fetch_valid_o = issue;
    fetch_pc_o    = fetch_pc_q;
    halt_valid_o  = ebreak_hit;
    halt_inst_o   = ebreak_hit ? q_inst_q[head_q] : '0;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (ebreak_hit) begin
      state_d = S_HALT;
    end else if (run && redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    q_pc_d   = q_pc_q;
    q_inst_d = q_inst_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        q_pc_d[tail_q]   = dl_pc_q[MEM_LAT-1];
        q_inst_d[tail_q] = dl_inst_q[MEM_LAT-1];
        tail_d           = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    dl_valid_d   = '0;
    dl_pc_d      = dl_pc_q;
    dl_inst_d    = dl_inst_q;
    dl_valid_d[0] = issue;
    if (issue) begin
      dl_pc_d[0]   = fetch_pc_q;
      dl_inst_d[0] = fetch_inst_i;
    end
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1] && !flush;
      dl_pc_d[i]    = dl_pc_q[i-1];
      dl_inst_d[i]  = dl_inst_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      dl_valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_inst_q[i] <= '0;
      end
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        dl_pc_q[i]   <= '0;
        dl_inst_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      dl_valid_q <= dl_valid_d;
      q_pc_q     <= q_pc_d;
      q_inst_q   <= q_inst_d;
      dl_pc_q    <= dl_pc_d;
      dl_inst_q  <= dl_inst_d;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Scoreboard bench for ifu_prefetch_queue: stimulus pushes expected {pc,inst} per
// dispatch; a negedge monitor pops on every handshake. Second instance: DEPTH=2, MEM_LAT=3.
module tb_ifu_prefetch_queue;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        ebreak_en;

  logic        redir, ready;
  logic [31:0] redir_pc;
  logic        ov, halted, f_valid, h_valid;
  logic [31:0] oinst, opc, f_pc, f_inst, h_inst;

  logic        redir2, ready2;
  logic [31:0] redir_pc2;
  logic        ov2, halted2, f_valid2, h_valid2;
  logic [31:0] oinst2, opc2, f_pc2, f_inst2, h_inst2;

  int   compared   = 0;
  int   mismatched = 0;
  int   fetch_cnt  = 0;
  int   halt_cnt   = 0;
  int   iss2       = 0;
  int   disp2      = 0;
  exp_t exp_q[$];
  exp_t exp2_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] pc, input logic eb);
    if (eb && pc == 32'h8000_000C) return EBREAK;
    return pc ^ 32'h5A5A_0003;
  endfunction

  always_comb f_inst  = mem(f_pc, ebreak_en);
  always_comb f_inst2 = mem(f_pc2, 1'b0);

  ifu_prefetch_queue dut (
    .clock(clk), .reset(rst_n), .redirect_valid(redir), .redirect_pc(redir_pc),
    .out_valid(ov), .out_ready(ready), .out_inst(oinst), .out_pc(opc), .halted(halted),
    .fetch_valid_o(f_valid), .fetch_pc_o(f_pc), .fetch_inst_i(f_inst),
    .halt_valid_o(h_valid), .halt_inst_o(h_inst)
  );

  ifu_prefetch_queue #(.XLEN(32), .DEPTH(2), .MEM_LAT(3), .RESET_PC(32'h8000_0000)) dut2 (
    .clock(clk), .reset(rst2_n), .redirect_valid(redir2), .redirect_pc(redir_pc2),
    .out_valid(ov2), .out_ready(ready2), .out_inst(oinst2), .out_pc(opc2), .halted(halted2),
    .fetch_valid_o(f_valid2), .fetch_pc_o(f_pc2), .fetch_inst_i(f_inst2),
    .halt_valid_o(h_valid2), .halt_inst_o(h_inst2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem(pc, ebreak_en);
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard pops on handshakes, plus DPI-call and occupancy bookkeeping.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (f_valid) fetch_cnt++;
      if (h_valid) begin
        halt_cnt++;
        chk("halt_inst", 64'(h_inst), 64'(EBREAK));
      end
      if (ov && ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_dispatch: got pc %h expected none", opc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", 64'(opc), 64'(e.pc));
          chk("out_inst", 64'(oinst), 64'(e.inst));
        end
      end else if (!ov) begin
        chk("idle_zero", {opc, oinst}, 64'd0);
      end
    end
    if (rst2_n) begin
      chk("t6_occupancy_le2", 64'((iss2 - disp2) <= 2), 64'd1);
      if (f_valid2) iss2++;
      if (ov2 && ready2) begin
        disp2++;
        if (exp2_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL t6_unexpected: got pc %h expected none", opc2);
        end else begin
          e = exp2_q.pop_front();
          chk("t6_out_pc", 64'(opc2), 64'(e.pc));
          chk("t6_out_inst", 64'(oinst2), 64'(e.inst));
        end
      end
    end
  end

  initial begin
    int base;
    logic [39:0] pat;
    rst_n = 1'b0; rst2_n = 1'b0; ebreak_en = 1'b0;
    redir = 1'b0; ready = 1'b0; redir_pc = '0;
    redir2 = 1'b0; ready2 = 1'b0; redir_pc2 = '0;
    step(3);
    chk("reset_out_valid", 64'(ov), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_out_pc", 64'(opc), 64'd0);

    // 1: streaming after reset release
    for (int k = 0; k < 6; k++) push_exp(32'h8000_0000 + 32'(4 * k));
    rst_n = 1'b1; ready = 1'b1;
    step(1);
    chk("t1_valid_after_1", 64'(ov), 64'd0);
    step(1);
    chk("t1_valid_after_2", 64'(ov), 64'd1);
    chk("t1_first_pc", 64'(opc), 64'h8000_0000);
    step(6);
    ready = 1'b0;

    // 2: stall, then drain
    step(10);
    chk("t2_fetch_total", 64'(fetch_cnt), 64'd10);
    chk("t2_held_valid", 64'(ov), 64'd1);
    chk("t2_held_pc", 64'(opc), 64'h8000_0018);
    for (int k = 0; k < 8; k++) push_exp(32'h8000_0018 + 32'(4 * k));
    ready = 1'b1;
    step(8);
    ready = 1'b0;

    // mid-operation reset: no fetch calls while held
    base = fetch_cnt;
    rst_n = 1'b0;
    step(2);
    chk("rst_mid_fetch", 64'(fetch_cnt - base), 64'd0);
    chk("rst_mid_valid", 64'(ov), 64'd0);

    // 3: redirect with 3 queued + 1 in flight, handshake in redirect cycle
    rst_n = 1'b1;
    step(4);
    chk("t3_head_pc", 64'(opc), 64'h8000_0000);
    push_exp(32'h8000_0000);
    for (int k = 0; k < 4; k++) push_exp(32'h8000_0100 + 32'(4 * k));
    redir = 1'b1; redir_pc = 32'h8000_0103; ready = 1'b1;
    #1;
    chk("t3_no_issue_on_redirect", 64'(f_valid), 64'd0);
    step(1);
    redir = 1'b0;
    chk("t3_flushed", 64'(ov), 64'd0);
    step(6);
    ready = 1'b0;

    // 5: redirect wrap at top of address space
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    push_exp(32'h0000_0004);
    step(1);
    redir = 1'b0; ready = 1'b1;
    step(5);
    ready = 1'b0;

    // 4: ebreak at 0x8000000C halts
    rst_n = 1'b0;
    step(1);
    ebreak_en = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(32'h8000_0000 + 32'(4 * k));
    base = fetch_cnt;
    rst_n = 1'b1; ready = 1'b1;
    step(5);
    chk("t4_not_halted_yet", 64'(halted), 64'd0);
    step(1);
    chk("t4_halted", 64'(halted), 64'd1);
    chk("t4_out_valid", 64'(ov), 64'd0);
    chk("t4_fetch_calls", 64'(fetch_cnt - base), 64'd5);
    chk("t4_halt_calls", 64'(halt_cnt), 64'd1);
    redir = 1'b1; redir_pc = 32'h8000_0200;
    step(1);
    redir = 1'b0;
    step(4);
    chk("t4_still_halted", 64'(halted), 64'd1);
    chk("t4_still_idle", 64'(ov), 64'd0);
    chk("t4_no_fetch_after", 64'(fetch_cnt - base), 64'd5);
    chk("t4_halt_once", 64'(halt_cnt), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // 6: DEPTH=2, MEM_LAT=3 with a fixed irregular ready pattern
    for (int k = 0; k < 40; k++) begin
      exp_t e;
      e.pc   = 32'h8000_0000 + 32'(4 * k);
      e.inst = mem(e.pc, 1'b0);
      exp2_q.push_back(e);
    end
    pat = 40'hB5_6D_3A_E9_C7;
    rst2_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ready2 = pat[i];
      step(1);
    end
    ready2 = 1'b1;
    step(16);
    ready2 = 1'b0;
    step(2);
    chk("t6_progress", 64'(disp2 >= 5), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
